// File: rtl/group_gather_pkg.sv
// Shared definitions for the group-wide operators: fill-side state encoding,
// lane-counter sizing and lane-slice position helper.
package group_gather_pkg;

    typedef enum logic [0:0] {
        ST_FILL = 1'b0,
        ST_HELD = 1'b1
    } fill_state_e;

    // Lane counter width; a group always has at least two lanes.
    function automatic int cnt_width(input int group_nb);
        return (group_nb > 2) ? $clog2(group_nb) : 1;
    endfunction

    // LSB position of lane k in a packed group word.
    function automatic int lane_lsb(input int k, input int num_width);
        return k * num_width;
    endfunction

endpackage

// File: rtl/group_gather.sv
// Stream-to-group packer: collects GROUP_NB scalar words into one packed
// group, with a fill register and an output register so upstream keeps flowing.
module group_gather
    import group_gather_pkg::*;
#(
    parameter int GROUP_NB  = 3,
    parameter int NUM_WIDTH = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_WIDTH-1:0]          up_data,
    input  logic                          up_last,
    input  logic                          up_valid,
    output logic                          up_rdy,
    output logic [NUM_WIDTH*GROUP_NB-1:0] dn_data,
    output logic                          dn_last,
    output logic                          dn_valid,
    input  logic                          dn_rdy
);

    localparam int CNT_W   = cnt_width(GROUP_NB);
    localparam int GROUP_W = NUM_WIDTH * GROUP_NB;
    localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(GROUP_NB - 1);

    fill_state_e          state_r;
    logic [CNT_W-1:0]     cnt_r;
    logic [GROUP_W-1:0]   fill_data_r;
    logic                 fill_last_r;
    logic                 up_rdy_r;
    logic [GROUP_W-1:0]   out_data_r;
    logic                 out_last_r;
    logic                 out_valid_r;

    logic [GROUP_W-1:0]   group_s;
    logic                 accept_s;
    logic                 complete_s;
    logic                 out_free_s;
    logic                 load_s;

    // Merge the incoming word into lane cnt; lanes past it read as zero for flush padding
    always_comb begin
        group_s = '0;
        for (int k = 0; k < GROUP_NB; k++) begin
            if (CNT_W'(k) < cnt_r) begin
                group_s[lane_lsb(k, NUM_WIDTH) +: NUM_WIDTH] = fill_data_r[lane_lsb(k, NUM_WIDTH) +: NUM_WIDTH];
            end else if (CNT_W'(k) == cnt_r) begin
                group_s[lane_lsb(k, NUM_WIDTH) +: NUM_WIDTH] = up_data;
            end else begin
                group_s[lane_lsb(k, NUM_WIDTH) +: NUM_WIDTH] = {NUM_WIDTH{1'b0}};
            end
        end
    end

    // Handshake decode; up_rdy_r is only high in FILL so accept implies FILL
    always_comb begin
        accept_s   = up_valid && up_rdy_r;
        complete_s = accept_s && (up_last || (cnt_r == LAST_LANE));
        out_free_s = !out_valid_r || dn_rdy;
        load_s     = out_free_s && ((state_r == ST_HELD) || complete_s);
    end

    // Fill-side FSM: lane counter, fill register, held group and registered up_rdy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_FILL;
            cnt_r       <= '0;
            fill_data_r <= '0;
            fill_last_r <= 1'b0;
            up_rdy_r    <= 1'b0;
        end else begin
            case (state_r)
                ST_FILL: begin
                    if (complete_s) begin
                        cnt_r <= '0;
                        if (out_free_s) begin
                            up_rdy_r <= 1'b1;
                        end else begin
                            fill_data_r <= group_s;
                            fill_last_r <= up_last;
                            state_r     <= ST_HELD;
                            up_rdy_r    <= 1'b0;
                        end
                    end else if (accept_s) begin
                        fill_data_r <= group_s;
                        cnt_r       <= cnt_r + CNT_W'(1);
                        up_rdy_r    <= 1'b1;
                    end else begin
                        up_rdy_r <= 1'b1;
                    end
                end
                ST_HELD: begin
                    if (out_free_s) begin
                        state_r  <= ST_FILL;
                        up_rdy_r <= 1'b1;
                    end else begin
                        up_rdy_r <= 1'b0;
                    end
                end
                default: begin
                    state_r  <= ST_FILL;
                    cnt_r    <= '0;
                    up_rdy_r <= 1'b0;
                end
            endcase
        end
    end

    // Output register: loads a held or freshly completed group, clears on drain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_r  <= '0;
            out_last_r  <= 1'b0;
            out_valid_r <= 1'b0;
        end else if (load_s) begin
            if (state_r == ST_HELD) begin
                out_data_r <= fill_data_r;
                out_last_r <= fill_last_r;
            end else begin
                out_data_r <= group_s;
                out_last_r <= up_last;
            end
            out_valid_r <= 1'b1;
        end else if (out_valid_r && dn_rdy) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    assign up_rdy   = up_rdy_r;
    assign dn_data  = out_data_r;
    assign dn_last  = out_last_r;
    assign dn_valid = out_valid_r;

endmodule
